tanhx_issue_ctrl: RTL and testbench
===================================

TANHX_ISSUE_CTRL -- requirements
Module: tanhx_issue_ctrl

Interface
REQ-001 Parameter DWIDTH, 32, operand/result width in bits (IEEE-754 single).
REQ-002 Parameter DEPTH, 4, input FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT, 64, maximum cycles to wait for core_valid (used only with TANHX_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_x  input  DWIDTH  operand to be sent to the tanh core.
REQ-007 in_valid  input  1  in_x is valid this cycle.
REQ-008 in_ready  output  1  FIFO can accept; push occurs when in_valid&in_ready.
REQ-009 core_x_in  output  DWIDTH  operand driven to core x_in.
REQ-010 core_start  output  1  drives core start.
REQ-011 core_y_out  input  DWIDTH  core y_out.
REQ-012 core_valid  input  1  core valid; result qualifier.
REQ-013 out_y  output  DWIDTH  captured result.
REQ-014 out_valid  output  1  out_y holds an unconsumed result.
REQ-015 out_ready  input  1  consumer accepts; pop when out_valid&out_ready.
REQ-016 busy  output  1  high in any state other than IDLE, or FIFO non-empty.
REQ-017 err_timeout  output  1  sticky timeout flag.

Function
REQ-018 Input FIFO: DEPTH entries, read/write pointers with one wrap bit; in_ready = not full; a push while full is blocked even if a pop occurs the same cycle; pointers wrap modulo DEPTH.
REQ-019 FSM states: IDLE, ISSUE, WAIT, GAP.
REQ-020 IDLE->ISSUE when FIFO non-empty and out_valid=0; the FIFO head is popped and registered into core_x_in on that edge.
REQ-021 ISSUE: core_start=1 for one cycle with core_x_in stable; next state WAIT.
REQ-022 WAIT: core_start stays 1 and core_x_in is held constant until core_valid is sampled 1.
REQ-023 On the edge where core_valid is sampled 1 in WAIT: out_y<=core_y_out, out_valid<=1, core_start<=0, next state GAP.
REQ-024 GAP: core_start=0 for exactly one cycle (minimum start-low gap required by the core), then IDLE.
REQ-025 Issue-to-result latency = core latency + 1 cycle; back-to-back operations are separated by at least GAP plus one IDLE cycle.
REQ-026 out_valid clears on out_valid&out_ready; out_y is held unchanged while out_valid=1 and out_ready=0.
REQ-027 No new operation is issued while out_valid=1; result capture therefore never overwrites an unconsumed result.
REQ-028 core_valid sampled high in IDLE, ISSUE or GAP is ignored (no capture, no state change).
REQ-029 Data is passed bit-exact; no floating-point interpretation, NaN/Inf/denormal operands are forwarded unmodified.

Reset
REQ-030 rst low asynchronously forces: FSM=IDLE, FIFO pointers=0, core_start=0, core_x_in=0, out_y=0, out_valid=0, err_timeout=0, watchdog counter=0; in_ready=1 after reset.
REQ-031 Reset mid-operation abandons the in-flight operand and all FIFO contents; a core_valid arriving after release is ignored per REQ-028.

Configuration
REQ-032 Macro TANHX_TIMEOUT_EN defined: counter runs in WAIT; if core_valid is not seen within TIMEOUT cycles of entering WAIT, core_start<=0, out_y<=32'h7FC00000, out_valid<=1, err_timeout<=1 (sticky until reset), next state GAP.
REQ-033 Macro TANHX_TIMEOUT_EN undefined: no counter is built, WAIT persists indefinitely, err_timeout is tied 0.

Verification
REQ-034 Reset release, push 32'h3F9D70A4 (1.23); core model returns 32'h3F57B2A0 after 3 cycles -> core_start high 4 cycles, out_y=32'h3F57B2A0, out_valid=1, then one start-low cycle.
REQ-035 Push 5 operands back-to-back with out_ready=1 -> in_ready low after 4 held, 5th accepted after first pop; results emerge in push order.
REQ-036 out_ready=0 with result pending, FIFO holding 32'h3F19999A (0.6) -> core_start stays 0 until out_ready=1 consumes result.
REQ-037 Push 32'h7FC80000 (NaN) and 32'hFF800000 (-Inf) -> core_x_in equals operands bit-exact.
REQ-038 TANHX_TIMEOUT_EN, TIMEOUT=64, core never responds -> after 64 WAIT cycles out_y=32'h7FC00000, err_timeout=1, FSM returns to IDLE; without macro, core_start remains 1.
REQ-039 rst low during WAIT with 2 entries queued -> all outputs at reset values immediately; late core_valid produces no out_valid.

Source files
------------

// File: rtl/tanhx_issue_ctrl.sv
// Operand FIFO and one-at-a-time issue sequencer for a tanh core with start/valid handshake.
// Define TANHX_TIMEOUT_EN to build the WAIT-state watchdog and the sticky err_timeout flag.
module tanhx_issue_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] core_x_in,
  output logic              core_start,
  input  logic [DWIDTH-1:0] core_y_out,
  input  logic              core_valid,
  output logic [DWIDTH-1:0] out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0] QNAN_C = DWIDTH'(32'h7FC0_0000);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("tanhx_issue_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [1:0]        state_r, state_nxt_s;
  logic              push_s, pop_s, empty_s, full_nxt_s, capture_s, timeout_s;
  logic              in_ready_r, busy_r, core_start_r, out_valid_r;
  logic [DWIDTH-1:0] core_x_in_r, out_y_r;

  // Handshake decode, FIFO pointer advance and FSM next state
  always_comb begin
    push_s    = in_valid && in_ready_r;
    empty_s   = (wr_ptr_r == rd_ptr_r);
    pop_s     = (state_r == ST_IDLE) && !empty_s && !out_valid_r;
    capture_s = (state_r == ST_WAIT) && core_valid;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                 (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (capture_s || timeout_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand storage; the pointers alone define which entries are live, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_x;
    end
  end

  // FSM, pointers and registered outputs; in_ready/busy are precomputed from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      core_x_in_r  <= {DWIDTH{1'b0}};
      out_y_r      <= {DWIDTH{1'b0}};
      out_valid_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      in_ready_r <= !full_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE) || (wr_ptr_nxt_s != rd_ptr_nxt_s);
      if (pop_s) begin
        core_x_in_r  <= mem_r[rd_ptr_r[AW-1:0]];
        core_start_r <= 1'b1;
      end else if (capture_s || timeout_s) begin
        core_start_r <= 1'b0;
      end
      if (capture_s) begin
        out_y_r     <= core_y_out;
        out_valid_r <= 1'b1;
      end else if (timeout_s) begin
        out_y_r     <= QNAN_C;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef TANHX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            err_r;

  assign timeout_s = (state_r == ST_WAIT) && !core_valid && (wd_cnt_r == WD_LAST);

  // Watchdog counts WAIT cycles from zero; error flag is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_r <= {WD_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (state_r == ST_WAIT) begin
        wd_cnt_r <= wd_cnt_r + WD_ONE;
      end else begin
        wd_cnt_r <= {WD_W{1'b0}};
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err_timeout = err_r;
`else
  assign timeout_s   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign core_start = core_start_r;
  assign core_x_in  = core_x_in_r;
  assign out_y      = out_y_r;
  assign out_valid  = out_valid_r;

endmodule

// File: tb/tb_tanhx_issue_ctrl.sv
// Self-checking bench for tanhx_issue_ctrl: transaction-level reference model, per-cycle compare,
// reactive tanh core stand-in and directed scenarios with literal expectations.
module tb_tanhx_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_x = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] core_x_in;
  logic        core_start;
  logic [31:0] core_y_out = 32'h0;
  logic        core_valid;
  logic [31:0] out_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        err_timeout;

  tanhx_issue_ctrl #(.DWIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
    .core_x_in(core_x_in), .core_start(core_start), .core_y_out(core_y_out),
    .core_valid(core_valid), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] core_f(input logic [31:0] x);
    if (x == 32'h3F9D70A4) return 32'h3F57B2A0;
    else return x ^ 32'h5A5A5A5A;
  endfunction

  // Core stand-in: valid pulses in the (lat+1)-th cycle that start is high
  logic stray = 1'b0;
  logic resp_v = 1'b0;
  int   lat = 3;
  int   st_cnt = 0;
  int   run = 0;
  int   last_run = 0;
  logic pcs = 1'b0;
  logic pv = 1'b0;
  logic [31:0] py = 32'h0;
  logic [31:0] issued_q[$];
  logic [31:0] got_q[$];
  assign core_valid = stray | resp_v;

  always @(negedge clk) begin
    if (core_start === 1'b1) st_cnt++; else st_cnt = 0;
    resp_v = (st_cnt == lat + 1);
    core_y_out = core_f(core_x_in);
    if (core_start === 1'b1) run++;
    else if (run > 0) begin last_run = run; run = 0; end
    if (core_start === 1'b1 && pcs !== 1'b1) issued_q.push_back(core_x_in);
    pcs = core_start;
    if (rst === 1'b1 && pv === 1'b1 && out_ready === 1'b1) got_q.push_back(py);
    pv = (rst === 1'b1) ? out_valid : 1'b0;
    py = out_y;
  end

  // Reference model: queue of operands plus "op in flight / age since issue" bookkeeping
  logic [31:0] m_q[$];
  bit          m_active, m_gap, m_rv, m_err;
  int          m_age;
  logic [31:0] m_x, m_res;
  int          mp_size;
  bit          mp_rv, mp_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 0; m_gap = 0; m_rv = 0; m_err = 0; m_age = 0;
      m_x = 32'h0; m_res = 32'h0;
    end else begin
      mp_size = m_q.size();
      mp_rv   = m_rv;
      mp_acc  = in_valid && (mp_size < DEPTH);
      if (mp_rv && out_ready) m_rv = 0;
      if (m_active) begin
        m_age++;
        if (m_age >= 2 && core_valid) begin
          m_res = core_y_out; m_rv = 1; m_active = 0; m_gap = 1;
        end
`ifdef TANHX_TIMEOUT_EN
        else if (m_age == TIMEOUT + 1) begin
          m_res = 32'h7FC00000; m_rv = 1; m_err = 1; m_active = 0; m_gap = 1;
        end
`endif
      end else if (m_gap) begin
        m_gap = 0;
      end else if (mp_size > 0 && !mp_rv) begin
        m_x = m_q.pop_front(); m_active = 1; m_age = 0;
      end
      if (mp_acc) m_q.push_back(in_x);
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("in_ready", in_ready, m_q.size() < DEPTH);
      chk("busy", busy, m_active || m_gap || (m_q.size() > 0));
      chk("core_start", core_start, m_active);
      chk("core_x_in", core_x_in, m_x);
      chk("out_valid", out_valid, m_rv);
      chk("out_y", out_y, m_res);
      chk("err_timeout", err_timeout, m_err);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return out_valid === 1'b1;
      1: return core_start === 1'b1;
      2: return busy === 1'b0 && out_valid === 1'b0;
      default: return got_q.size() >= 6;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int max);
    int i;
    for (i = 0; i < max && !cond(sel); i++) step(1);
    if (!cond(sel)) begin
      n_cmp++; n_err++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, max);
    end
  endtask

  task automatic push(input logic [31:0] x);
    bit acc = 0;
    in_x = x; in_valid = 1'b1;
    for (int g = 0; g < 50 && !acc; g++) begin
      acc = (in_ready === 1'b1);
      step(1);
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL push: operand %h not accepted within 50 cycles", x);
    end
  endtask

  logic [31:0] ops[6] = '{32'h3F800000, 32'hBF800000, 32'h00000001,
                          32'h7F7FFFFF, 32'h80000000, 32'h41200000};

  initial begin
    int k, guard, cnt;
    bit acc, saw_full;
    step(3);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_core_start", core_start, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_y", out_y, 32'h0);
    chk("rst_err", err_timeout, 32'd0);
    rst = 1'b1;
    step(2);

    // Single operation, core latency 3
    out_ready = 1'b0;
    push(32'h3F9D70A4);
    wait_for("t1_result", 0, 20);
    step(1);
    chk("t1_out_y", out_y, 32'h3F57B2A0);
    chk("t1_start_cycles", last_run, 32'd4);
    chk("t1_gap_start", core_start, 32'd0);
    chk("t1_out_valid", out_valid, 32'd1);
    out_ready = 1'b1;
    step(3);

    // Back-to-back pushes, FIFO fills, results in order
    got_q.delete();
    k = 0; guard = 0; saw_full = 0;
    while (k < 6 && guard < 200) begin
      in_x = ops[k]; in_valid = 1'b1;
      acc = (in_ready === 1'b1);
      if (!acc) saw_full = 1;
      step(1);
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    chk("t2_saw_full", saw_full, 32'd1);
    wait_for("t2_results", 3, 200);
    chk("t2_count", got_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk("t2_order", got_q[i], core_f(ops[i]));
    wait_for("t2_drain", 2, 40);

    // Pending result blocks the next issue
    out_ready = 1'b0;
    push(32'h40000000);
    push(32'h3F19999A);
    wait_for("t3_result", 0, 30);
    cnt = 0;
    repeat (10) begin
      if (core_start === 1'b1) cnt++;
      step(1);
    end
    chk("t3_no_start", cnt, 32'd0);
    chk("t3_busy", busy, 32'd1);
    out_ready = 1'b1;
    wait_for("t3_issue", 1, 10);
    chk("t3_x", core_x_in, 32'h3F19999A);
    wait_for("t3_drain", 2, 40);

    // Special values pass bit-exact
    issued_q.delete();
    push(32'h7FC80000);
    push(32'hFF800000);
    wait_for("t4_drain", 2, 60);
    chk("t4_count", issued_q.size(), 32'd2);
    chk("t4_nan", issued_q[0], 32'h7FC80000);
    chk("t4_ninf", issued_q[1], 32'hFF800000);

    // Stray valid while idle is ignored
    stray = 1'b1; step(2); stray = 1'b0; step(2);
    chk("stray_out_valid", out_valid, 32'd0);
    chk("stray_busy", busy, 32'd0);

    // Core answers only during ISSUE, then never
    lat = 0; out_ready = 1'b0;
    push(32'h3E800000);
    step(75);
`ifdef TANHX_TIMEOUT_EN
    chk("to_out_y", out_y, 32'h7FC00000);
    chk("to_err", err_timeout, 32'd1);
    chk("to_out_valid", out_valid, 32'd1);
    chk("to_idle", busy, 32'd0);
    chk("to_start", core_start, 32'd0);
`else
    chk("nto_start", core_start, 32'd1);
    chk("nto_err", err_timeout, 32'd0);
    chk("nto_out_valid", out_valid, 32'd0);
`endif
    rst = 1'b0; step(2); rst = 1'b1; step(2);

    // Reset in WAIT with two queued entries
    lat = 10; out_ready = 1'b1;
    push(32'h3F000000);
    push(32'h3F400000);
    push(32'h3FC00000);
    step(1);
    chk("t9_pre_start", core_start, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t9_start", core_start, 32'd0);
    chk("t9_x", core_x_in, 32'h0);
    chk("t9_in_ready", in_ready, 32'd1);
    chk("t9_busy", busy, 32'd0);
    chk("t9_out_valid", out_valid, 32'd0);
    chk("t9_out_y", out_y, 32'h0);
    chk("t9_err", err_timeout, 32'd0);
    step(2);
    rst = 1'b1;
    step(1);
    stray = 1'b1; step(2); stray = 1'b0; step(3);
    chk("t9_late_valid", out_valid, 32'd0);
    chk("t9_late_busy", busy, 32'd0);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
